or_gate_checker: RTL and testbench
==================================

# or_gate_checker

Synthesizable self-checking response monitor for the two-input OR gate, on the receiving end of the gate stimulus interface. The stimulus source drives `in1`/`in2` with a valid strobe. The checker computes the expected `in1 | in2`, aligns it with the DUT's `out1` after a fixed latency, and counts vectors and mismatches. It captures the first failing vector and reports a pass/fail verdict after a programmed number of vectors, so gate regressions run on hardware or in simulation without a behavioural bench.

## Interface
- `NUM_VECTORS`, default 4: vectors compared per run; range 1 .. 2^CNT_W-1.
- `CNT_W`, default 8: width of the vector and error counters.
- `LATENCY`, default 0: DUT output delay in clock cycles; range 0..3.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `vld`  in  1  stimulus valid; `in1`/`in2` are applied to the DUT this cycle.
- `in1`  in  1  stimulus bit 1, as driven to the DUT.
- `in2`  in  1  stimulus bit 2, as driven to the DUT.
- `out1`  in  1  DUT response.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`=1; 1 iff `err_count`==0.
- `vec_count`  out  CNT_W  vectors compared this run.
- `err_count`  out  CNT_W  mismatches this run; saturates at all-ones.
- `fail_valid`  out  1  a mismatch has been captured this run.
- `fail_in1`, `fail_in2`, `fail_out1`  out  1 each  stimulus and observed response of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → RUN.
  - RUN: final compare → DONE.
  - DONE: `start`=1 → RUN.
  - `rst` → IDLE from any state.
- Entering RUN clears `vec_count`, `err_count`, `fail_*`, the issue counter and the expectation pipeline.
- Issue side: in RUN, a `vld`=1 cycle is accepted only while the issue count is below `NUM_VECTORS`. An accepted cycle pushes {expected = `in1|in2`, `in1`, `in2`, tag=1} into a LATENCY-deep shift pipeline. `vld` in IDLE/DONE, or beyond `NUM_VECTORS`, is ignored.
- Compare side: when the tagged pipeline output is 1, `out1` is sampled that same cycle and compared with the expected value.
  - With LATENCY=0, the pipeline is bypassed and comparison happens in the cycle `vld` is accepted.
- Per compare:
  - `vec_count` += 1.
  - On mismatch, `err_count` += 1 (saturating).
  - If `fail_valid`=0, latch `fail_in1`/`fail_in2`/`fail_out1` and set `fail_valid`.
- When a compare brings `vec_count` to `NUM_VECTORS`, the FSM enters DONE on that edge. Remaining pipeline contents are discarded.
- `pass` = `done` & (`err_count`==0). `pass` is 0 outside DONE.
- `start` while in RUN is ignored.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `pass`=0, `vec_count`=0, `err_count`=0, `fail_valid`=0, `fail_in1`=`fail_in2`=`fail_out1`=0.
- `start` sampled at edge E → `busy`=1 from E.
- `vld` accepted at edge V → compared against `out1` sampled at edge V+LATENCY. Counters reflect that compare after the same edge.
- Last compare at edge L → `busy`=0 and `done`=1 and `pass` valid after L.
- Minimum run length: `NUM_VECTORS` + LATENCY cycles.
- Back-to-back `vld` is accepted every cycle with no stall; gaps in `vld` are allowed.
- `rst` mid-run: the next edge returns to IDLE with all outputs at reset values, and the pipeline is flushed.
- A mismatch on the final vector is counted and captured before DONE.

## Test plan
- Defaults, correct DUT: `start`, then 4 consecutive `vld` with (0,0),(1,0),(0,1),(1,1) and `out1` = 0,1,1,1 → `done`=1 one cycle after the 4th vector, `pass`=1, `vec_count`=4, `err_count`=0, `fail_valid`=0.
- Stuck-at-0 DUT (`out1`=0): same vectors → `err_count`=3, `pass`=0. `fail_in1`=1, `fail_in2`=0, `fail_out1`=0 are captured from vector 2.
- LATENCY=2 with `out1` delayed 2 cycles, 2-cycle gap between vectors 2 and 3 → `pass`=1, `done` 1 cycle after the last `vld` + 2.
- Extra `vld` beyond 4 in RUN, and `vld` in IDLE/DONE → `vec_count` stays at 4 and counters are unchanged.
- `rst` asserted after vector 2 → all outputs 0 next cycle. A following `start` plus 4 good vectors → `pass`=1.
- `start` in DONE after a failed run → counters and `fail_valid` clear. A rerun with a good DUT → `pass`=1.

Source files
------------

// File: rtl/or_gate_checker.sv
// Response monitor for a two-input OR gate: aligns in1|in2 with the DUT's out1
// after LATENCY cycles, counts vectors and mismatches, and reports a verdict.
module or_gate_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8,
    parameter int LATENCY     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic             in1,
    input  logic             in2,
    input  logic             out1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic             fail_in1,
    output logic             fail_in2,
    output logic             fail_out1
);
    // One-hot so busy/done come straight off state flops.
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    localparam logic [CNT_W-1:0] NV  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef struct packed {
        logic tag;
        logic exp;
        logic in1;
        logic in2;
    } ent_t;

    logic [2:0]       state;
    logic [CNT_W-1:0] issue_cnt;
    logic             accept;
    logic             cmp;
    logic             mism;
    logic             last;
    logic [CNT_W-1:0] vec_next;
    ent_t             ent_in;
    ent_t             ent_out;

    assign accept = state[1] && vld && (issue_cnt < NV);
    assign ent_in = '{tag: accept, exp: in1 | in2, in1: in1, in2: in2};

    generate
        if (LATENCY == 0) begin : g_bypass
            assign ent_out = ent_in;
        end else begin : g_pipe
            ent_t pipe [LATENCY];
            // Flushed whenever not running, so leftovers from a finished run never compare.
            always_ff @(posedge clk) begin
                if (rst || !state[1]) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= ent_in;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign ent_out = pipe[LATENCY-1];
        end
    endgenerate

    assign cmp      = state[1] && ent_out.tag;
    assign mism     = cmp && (out1 != ent_out.exp);
    assign vec_next = vec_count + ONE;
    assign last     = cmp && (vec_next == NV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            issue_cnt  <= '0;
            vec_count  <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_in1   <= 1'b0;
            fail_in2   <= 1'b0;
            fail_out1  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        issue_cnt  <= '0;
                        vec_count  <= '0;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_in1   <= 1'b0;
                        fail_in2   <= 1'b0;
                        fail_out1  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) issue_cnt <= issue_cnt + ONE;
                    if (cmp) vec_count <= vec_next;
                    if (mism) begin
                        if (err_count != '1) err_count <= err_count + ONE;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_in1   <= ent_out.in1;
                            fail_in2   <= ent_out.in2;
                            fail_out1  <= out1;
                        end
                    end
                    if (last) begin
                        state <= S_DONE;
                        pass  <= (err_count == '0) && !mism;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = state[1];
    assign done = state[2];
endmodule

// File: tb/tb_or_gate_checker.sv
// Bench: two checkers (LATENCY 0 and 2) against a queue-based reference model
// plus literal expectations for the directed scenarios.
module tb_or_gate_checker;
    localparam int NV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = '0, vld = '0, in1 = '0, in2 = '0;
    logic       out1_0 = 1'b0;
    logic       d1 = 1'b0, d2 = 1'b0;
    logic [1:0] busy, done, pass, fv, fa, fb, fo;
    logic [1:0][7:0] vec, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate under test for the LATENCY=2 checker: a correct OR delayed two cycles.
    always @(posedge clk) begin
        d1 <= in1[1] | in2[1];
        d2 <= d1;
    end

    or_gate_checker #(.NUM_VECTORS(NV), .CNT_W(8), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .vld(vld[0]), .in1(in1[0]), .in2(in2[0]),
        .out1(out1_0), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .vec_count(vec[0]),
        .err_count(err[0]), .fail_valid(fv[0]), .fail_in1(fa[0]), .fail_in2(fb[0]), .fail_out1(fo[0]));

    or_gate_checker #(.NUM_VECTORS(NV), .CNT_W(8), .LATENCY(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .vld(vld[1]), .in1(in1[1]), .in2(in2[1]),
        .out1(d2), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .vec_count(vec[1]),
        .err_count(err[1]), .fail_valid(fv[1]), .fail_in1(fa[1]), .fail_in2(fb[1]), .fail_out1(fo[1]));

    // Reference model: mode 0 idle, 1 run, 2 done; pending compares kept as timestamped entries.
    typedef struct { int k; int due; bit e; bit a; bit b; } pend_t;
    pend_t pq[$];
    int m_mode[2], m_vec[2], m_err[2], m_iss[2];
    bit m_fv[2], m_fa[2], m_fb[2], m_fo[2];
    int cyc = 0;

    task automatic purge(int k);
        for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].k == k) pq.delete(i);
    endtask

    task automatic clr(int k);
        m_vec[k] = 0; m_err[k] = 0; m_iss[k] = 0;
        m_fv[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_fo[k] = 0;
        purge(k);
    endtask

    task automatic step(int k, int lat, bit s, bit v, bit a, bit b, bit o);
        int idx;
        pend_t p;
        if (rst) begin
            m_mode[k] = 0;
            clr(k);
            return;
        end
        if (m_mode[k] != 1) begin
            if (s) begin m_mode[k] = 1; clr(k); end
            return;
        end
        if (v && m_iss[k] < NV) begin
            pq.push_back('{k, cyc + lat, a | b, a, b});
            m_iss[k]++;
        end
        idx = -1;
        for (int i = 0; i < pq.size(); i++) if (pq[i].k == k) begin idx = i; break; end
        if (idx >= 0 && pq[idx].due == cyc) begin
            p = pq[idx];
            pq.delete(idx);
            m_vec[k]++;
            if (o != p.e) begin
                if (m_err[k] < 255) m_err[k]++;
                if (!m_fv[k]) begin m_fv[k] = 1; m_fa[k] = p.a; m_fb[k] = p.b; m_fo[k] = o; end
            end
            if (m_vec[k] == NV) begin m_mode[k] = 2; purge(k); end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        step(0, 0, start[0], vld[0], in1[0], in2[0], out1_0);
        step(1, 2, start[1], vld[1], in1[1], in2[1], d2);
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle, every output of both checkers against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), busy[k], m_mode[k] == 1);
            chk($sformatf("done%0d", k), done[k], m_mode[k] == 2);
            chk($sformatf("pass%0d", k), pass[k], (m_mode[k] == 2) && (m_err[k] == 0));
            chk($sformatf("vec%0d", k), vec[k], m_vec[k]);
            chk($sformatf("err%0d", k), err[k], m_err[k]);
            chk($sformatf("fail_valid%0d", k), fv[k], m_fv[k]);
            chk($sformatf("fail_in1_%0d", k), fa[k], m_fa[k]);
            chk($sformatf("fail_in2_%0d", k), fb[k], m_fb[k]);
            chk($sformatf("fail_out1_%0d", k), fo[k], m_fo[k]);
        end
    end

    // One cycle of stimulus, driven right after a falling edge.
    task automatic drive(int k, bit s, bit v, bit a, bit b, bit o);
        start = '0; vld = '0; in1 = '0; in2 = '0;
        start[k] = s; vld[k] = v; in1[k] = a; in2[k] = b;
        if (k == 0) out1_0 = o;
        @(negedge clk);
    endtask

    bit ta [4] = '{0, 1, 0, 1};
    bit tb [4] = '{0, 0, 1, 1};
    bit to [4] = '{0, 1, 1, 1};

    task automatic run_good0();
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, ta[i], tb[i], to[i]);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("reset_busy", busy[0], 0);
        chk("reset_vec", vec[0], 0);
        rst = 1'b0;

        // vld while idle is ignored
        drive(0, 0, 1, 1, 1, 1);
        drive(0, 0, 1, 1, 1, 0);
        chk("idle_vld_vec", vec[0], 0);
        chk("idle_vld_busy", busy[0], 0);

        // good run: done right after the 4th vector
        run_good0();
        chk("t1_done", done[0], 1);
        chk("t1_pass", pass[0], 1);
        chk("t1_vec", vec[0], 4);
        chk("t1_err", err[0], 0);
        chk("t1_fv", fv[0], 0);

        // vld in DONE with a wrong response changes nothing
        drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        chk("done_vld_vec", vec[0], 4);
        chk("done_vld_err", err[0], 0);

        // stuck-at-0 gate
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, ta[i], tb[i], 0);
        chk("sa0_done", done[0], 1);
        chk("sa0_err", err[0], 3);
        chk("sa0_pass", pass[0], 0);
        chk("sa0_fv", fv[0], 1);
        chk("sa0_fin1", fa[0], 1);
        chk("sa0_fin2", fb[0], 0);
        chk("sa0_fout1", fo[0], 0);

        // restart from DONE clears everything
        drive(0, 1, 0, 0, 0, 0);
        chk("rerun_busy", busy[0], 1);
        chk("rerun_err", err[0], 0);
        chk("rerun_fv", fv[0], 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, ta[i], tb[i], to[i]);
        chk("rerun_pass", pass[0], 1);

        // reset mid-run after two vectors
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, ta[0], tb[0], to[0]);
        drive(0, 0, 1, ta[1], tb[1], 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("midrst_busy", busy[0], 0);
        chk("midrst_vec", vec[0], 0);
        chk("midrst_err", err[0], 0);
        chk("midrst_fv", fv[0], 0);
        run_good0();
        chk("postrst_pass", pass[0], 1);

        // LATENCY=2 with a two-cycle gap, then extra vld beyond NV
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 1, ta[0], tb[0], 0);
        drive(1, 0, 1, ta[1], tb[1], 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, ta[2], tb[2], 0);
        drive(1, 0, 1, ta[3], tb[3], 0);
        drive(1, 0, 1, 1, 1, 0);
        chk("lat2_done_early", done[1], 0);
        chk("lat2_busy", busy[1], 1);
        drive(1, 0, 1, 0, 1, 0);
        chk("lat2_done", done[1], 1);
        chk("lat2_pass", pass[1], 1);
        chk("lat2_vec", vec[1], 4);
        drive(1, 0, 1, 1, 0, 0);
        chk("lat2_vec_hold", vec[1], 4);

        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
